// File: rtl/unified_mem_responder.sv
// Shared instruction/data memory responder.
// Arbitrates fetch and data requests onto one byte-addressed single-port array
// through an IDLE -> WAIT -> ACCESS -> DONE sequence. Each requester sees a
// one-cycle rvalid pulse on completion.
module unified_mem_responder #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_wdata,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
   localparam logic SIDE_FETCH = 1'b0;
   localparam logic SIDE_DATA  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [CNT_W-1:0]   wait_cnt_r;
   logic               last_grant_r;
   logic               grant_s;
   logic               grant_side_s;
   logic               side_r;
   logic [ADDR_W-1:0]  addr_r;
   logic               we_r;
   logic [2:0]         funct3_r;
   logic [31:0]        wdata_r;
   logic [7:0]         mem_r [DEPTH];
   logic [ADDR_W-3:0]  word_idx_s;
   logic [31:0]        rd_word_s;
   logic               err_s;
   logic [31:0]        load_s;
   logic [3:0]         be_s;
   logic [31:0]        wlane_s;
   logic               mem_we_s;
   logic               if_rvalid_r;
   logic [31:0]        if_rdata_r;
   logic               if_err_r;
   logic               d_rvalid_r;
   logic [31:0]        d_rdata_r;
   logic               d_err_r;
   logic               busy_r;
   logic               unused_s;

   // Illegal size code or misaligned address for the given access.
   function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
      logic illegal;
      logic misaligned;
      case (f3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = we;
         default:                illegal = 1'b1;
      endcase
      misaligned = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
      return illegal | misaligned;
   endfunction

   // Select the addressed lane of a little-endian word and sign/zero extend it.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lo, 3'b000};
      case (f3)
         3'b000:  res = {{24{sh[7]}}, sh[7:0]};
         3'b001:  res = {{16{sh[15]}}, sh[15:0]};
         3'b100:  res = {24'd0, sh[7:0]};
         3'b101:  res = {16'd0, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // Only the decoded address bits matter; upper bits alias.
   assign unused_s = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and arbitration (data wins a tie unless it was served last).
   always_comb begin
      state_s      = state_r;
      grant_s      = 1'b0;
      grant_side_s = SIDE_FETCH;
      case (state_r)
         ST_IDLE: begin
            if (if_req || d_req) begin
               grant_s = 1'b1;
               if (if_req && d_req) begin
                  grant_side_s = ~last_grant_r;
               end else begin
                  grant_side_s = d_req;
               end
               state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == CNT_LAST) begin
               state_s = ST_ACCESS;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_ACCESS: state_s = ST_DONE;
         ST_DONE:   state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Wait-state counter, only advances in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= '0;
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != CNT_LAST)) begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
         wait_cnt_r <= '0;
      end
   end

   // Capture the granted request; fetches are treated as aligned word loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         side_r   <= SIDE_FETCH;
         addr_r   <= '0;
         we_r     <= 1'b0;
         funct3_r <= 3'b010;
         wdata_r  <= 32'd0;
      end else if (grant_s) begin
         side_r <= grant_side_s;
         if (grant_side_s == SIDE_DATA) begin
            addr_r   <= d_addr[ADDR_W-1:0];
            we_r     <= d_we;
            funct3_r <= d_funct3;
            wdata_r  <= d_wdata;
         end else begin
            addr_r   <= if_addr[ADDR_W-1:0];
            we_r     <= 1'b0;
            funct3_r <= 3'b010;
            wdata_r  <= 32'd0;
         end
      end else begin
         side_r   <= side_r;
         addr_r   <= addr_r;
         we_r     <= we_r;
         funct3_r <= funct3_r;
         wdata_r  <= wdata_r;
      end
   end

   // Array read, load extension, error decode and store lane steering.
   always_comb begin
      word_idx_s = addr_r[ADDR_W-1:2];
      rd_word_s  = {mem_r[{word_idx_s, 2'd3}], mem_r[{word_idx_s, 2'd2}],
                    mem_r[{word_idx_s, 2'd1}], mem_r[{word_idx_s, 2'd0}]};
      err_s      = access_err(we_r, funct3_r, addr_r[1:0]);
      if (err_s || we_r) begin
         load_s = 32'd0;
      end else begin
         load_s = load_extend(funct3_r, addr_r[1:0], rd_word_s);
      end
      case (funct3_r[1:0])
         2'b00: begin
            be_s    = 4'b0001 << addr_r[1:0];
            wlane_s = {4{wdata_r[7:0]}};
         end
         2'b01: begin
            be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
            wlane_s = {2{wdata_r[15:0]}};
         end
         2'b10: begin
            be_s    = 4'b1111;
            wlane_s = wdata_r;
         end
         default: begin
            be_s    = 4'b0000;
            wlane_s = wdata_r;
         end
      endcase
      mem_we_s = (state_r == ST_ACCESS) && we_r && !err_s && !rst;
   end

   // Array write on the edge that ends ACCESS; reset on that edge suppresses it.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[{word_idx_s, 2'(i)}] <= wlane_s[8*i +: 8];
            end
         end
      end
   end

   // Registered responses, completion pulses, fairness history and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rvalid_r  <= 1'b0;
         if_rdata_r   <= 32'd0;
         if_err_r     <= 1'b0;
         d_rvalid_r   <= 1'b0;
         d_rdata_r    <= 32'd0;
         d_err_r      <= 1'b0;
         last_grant_r <= SIDE_FETCH;
         busy_r       <= 1'b0;
      end else begin
         if_rvalid_r <= (state_r == ST_ACCESS) && (side_r == SIDE_FETCH);
         d_rvalid_r  <= (state_r == ST_ACCESS) && (side_r == SIDE_DATA);
         if ((state_r == ST_ACCESS) && (side_r == SIDE_FETCH)) begin
            if_rdata_r <= load_s;
            if_err_r   <= err_s;
         end else begin
            if_rdata_r <= if_rdata_r;
            if_err_r   <= if_err_r;
         end
         if ((state_r == ST_ACCESS) && (side_r == SIDE_DATA)) begin
            d_rdata_r <= load_s;
            d_err_r   <= err_s;
         end else begin
            d_rdata_r <= d_rdata_r;
            d_err_r   <= d_err_r;
         end
         if (state_r == ST_DONE) begin
            last_grant_r <= side_r;
         end else begin
            last_grant_r <= last_grant_r;
         end
         busy_r <= (state_s != ST_IDLE);
      end
   end

   assign if_rvalid = if_rvalid_r;
   assign if_rdata  = if_rdata_r;
   assign if_err    = if_err_r;
   assign d_rvalid  = d_rvalid_r;
   assign d_rdata   = d_rdata_r;
   assign d_err     = d_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: directed literal cases plus randomized
// traffic, all checked every cycle against a transaction-level memory model.
module tb_unified_mem_responder;

   localparam int AW  = 12;
   localparam int MWS = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a       [2];
   logic        if_req_a    [2];
   logic [31:0] if_addr_a   [2];
   logic        if_rvalid_a [2];
   logic [31:0] if_rdata_a  [2];
   logic        if_err_a    [2];
   logic        d_req_a     [2];
   logic        d_we_a      [2];
   logic [31:0] d_addr_a    [2];
   logic [2:0]  d_funct3_a  [2];
   logic [31:0] d_wdata_a   [2];
   logic        d_rvalid_a  [2];
   logic [31:0] d_rdata_a   [2];
   logic        d_err_a     [2];
   logic        busy_a      [2];

   unified_mem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst_a[0]),
      .if_req(if_req_a[0]), .if_addr(if_addr_a[0]), .if_rvalid(if_rvalid_a[0]),
      .if_rdata(if_rdata_a[0]), .if_err(if_err_a[0]),
      .d_req(d_req_a[0]), .d_we(d_we_a[0]), .d_addr(d_addr_a[0]), .d_funct3(d_funct3_a[0]),
      .d_wdata(d_wdata_a[0]), .d_rvalid(d_rvalid_a[0]), .d_rdata(d_rdata_a[0]),
      .d_err(d_err_a[0]), .busy(busy_a[0])
   );

   unified_mem_responder #(.ADDR_W(AW), .WAIT_STATES(MWS)) dut1 (
      .clk(clk), .rst(rst_a[1]),
      .if_req(if_req_a[1]), .if_addr(if_addr_a[1]), .if_rvalid(if_rvalid_a[1]),
      .if_rdata(if_rdata_a[1]), .if_err(if_err_a[1]),
      .d_req(d_req_a[1]), .d_we(d_we_a[1]), .d_addr(d_addr_a[1]), .d_funct3(d_funct3_a[1]),
      .d_wdata(d_wdata_a[1]), .d_rvalid(d_rvalid_a[1]), .d_rdata(d_rdata_a[1]),
      .d_err(d_err_a[1]), .busy(busy_a[1])
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- transaction-level model of instance 1 ----------------
   logic [7:0]  mm [4096];
   bit          chk_en = 1'b0;
   int          cyc    = 0;
   int          gcyc   = 0;
   int          due    = -1;
   bit          act    = 1'b0;
   bit          m_side = 1'b0;
   bit          m_last = 1'b0;
   bit          m_we   = 1'b0;
   int          m_addr = 0;
   logic [2:0]  m_f3   = 3'd0;
   logic [31:0] m_wd   = 32'd0;
   logic [31:0] e_if_rd = 32'd0;
   logic [31:0] e_d_rd  = 32'd0;
   bit          e_if_err = 1'b0;
   bit          e_d_err  = 1'b0;

   task automatic m_commit(output logic [31:0] res, output bit err);
      int n;
      bit legal;
      n     = (m_f3[1:0] == 2'd0) ? 1 : ((m_f3[1:0] == 2'd1) ? 2 : 4);
      legal = m_we ? (m_f3 <= 3'd2) : (m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || ((m_addr % n) != 0);
      res   = 32'd0;
      if (!err) begin
         if (m_we) begin
            for (int i = 0; i < n; i++) mm[(m_addr + i) % 4096] = 8'(m_wd >> (8 * i));
         end else begin
            for (int i = 0; i < n; i++) res = res | (32'(mm[(m_addr + i) % 4096]) << (8 * i));
            if (!m_f3[2] && (n < 4) && res[8*n-1]) res = res | ~((32'd1 << (8 * n)) - 32'd1);
         end
      end
   endtask

   initial begin
      bit          act0;
      bit          rv_f;
      bit          rv_d;
      bit          busy_e;
      logic [31:0] res;
      bit          err;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            cyc++;
            act0   = act;
            rv_f   = act0 && (cyc == due) && !m_side;
            rv_d   = act0 && (cyc == due) && m_side;
            busy_e = act0 && (cyc > gcyc);
            if (act0 && (cyc == due)) begin
               m_commit(res, err);
               if (m_side) begin
                  e_d_rd  = res;
                  e_d_err = err;
               end else begin
                  e_if_rd  = res;
                  e_if_err = err;
               end
               m_last = m_side;
               act    = 1'b0;
            end
            chk1("if_rvalid", if_rvalid_a[1], rv_f);
            chk1("d_rvalid", d_rvalid_a[1], rv_d);
            chk("if_rdata", if_rdata_a[1], e_if_rd);
            chk1("if_err", if_err_a[1], e_if_err);
            chk("d_rdata", d_rdata_a[1], e_d_rd);
            chk1("d_err", d_err_a[1], e_d_err);
            chk1("busy", busy_a[1], busy_e);
            if (rst_a[1]) begin
               act      = 1'b0;
               due      = -1;
               m_last   = 1'b0;
               e_if_rd  = 32'd0;
               e_d_rd   = 32'd0;
               e_if_err = 1'b0;
               e_d_err  = 1'b0;
            end else if (!act0 && (if_req_a[1] || d_req_a[1])) begin
               m_side = (if_req_a[1] && d_req_a[1]) ? !m_last : d_req_a[1];
               if (m_side) begin
                  m_we   = d_we_a[1];
                  m_addr = int'(d_addr_a[1] % 32'd4096);
                  m_f3   = d_funct3_a[1];
                  m_wd   = d_wdata_a[1];
               end else begin
                  m_we   = 1'b0;
                  m_addr = int'(if_addr_a[1] % 32'd4096);
                  m_f3   = 3'd2;
                  m_wd   = 32'd0;
               end
               act  = 1'b1;
               gcyc = cyc;
               due  = cyc + 2 + MWS;
            end
         end
      end
   end

   // ---------------- directed access helper ----------------
   task automatic op(input int k, input bit side, input bit we, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
      bit found;
      found = 1'b0;
      rd    = 32'd0;
      er    = 1'b0;
      lat   = -1;
      @(posedge clk); #1;
      if (side) begin
         d_we_a[k]     = we;
         d_addr_a[k]   = addr;
         d_funct3_a[k] = f3;
         d_wdata_a[k]  = wd;
         d_req_a[k]    = 1'b1;
      end else begin
         if_addr_a[k] = addr;
         if_req_a[k]  = 1'b1;
      end
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (side ? d_rvalid_a[k] : if_rvalid_a[k]) begin
            found = 1'b1;
            lat   = c;
            rd    = side ? d_rdata_a[k] : if_rdata_a[k];
            er    = side ? d_err_a[k] : if_err_a[k];
         end
      end
      chk1("op_completed", found, 1'b1);
      @(posedge clk); #1;
      d_req_a[k]  = 1'b0;
      if_req_a[k] = 1'b0;
   endtask

   task automatic xop(input string name, input int k, input bit side, input bit we,
                      input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
      logic [31:0] rd;
      logic        er;
      int          lat;
      op(k, side, we, addr, f3, wd, rd, er, lat);
      chk({name, "_rdata"}, rd, exp_rd);
      chk1({name, "_err"}, er, exp_er);
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   function automatic logic [31:0] rand_addr(input logic [1:0] sz);
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_F03F) | 32'h0000_0100;
      if ($urandom_range(0, 3) != 0) begin
         if (sz == 2'd2) a[1:0] = 2'b00;
         else if (sz == 2'd1) a[0] = 1'b0;
      end
      return a;
   endfunction

   task automatic drive_d(input int ncyc);
      bit done;
      for (int c = 0; c < ncyc + 40; c++) begin
         @(negedge clk);
         done = d_rvalid_a[1];
         @(posedge clk); #1;
         if (d_req_a[1] && !done) continue;
         if ((c < ncyc) && ($urandom_range(0, 2) != 0)) begin
            d_we_a[1]     = 1'($urandom_range(0, 1));
            d_funct3_a[1] = 3'($urandom_range(0, 7));
            d_addr_a[1]   = rand_addr(d_funct3_a[1][1:0]);
            d_wdata_a[1]  = $urandom();
            d_req_a[1]    = 1'b1;
         end else begin
            d_req_a[1] = 1'b0;
            if (c >= ncyc) break;
         end
      end
      chk1("d_drain", d_req_a[1], 1'b0);
   endtask

   task automatic drive_if(input int ncyc);
      bit done;
      for (int c = 0; c < ncyc + 40; c++) begin
         @(negedge clk);
         done = if_rvalid_a[1];
         @(posedge clk); #1;
         if (if_req_a[1] && !done) continue;
         if ((c < ncyc) && ($urandom_range(0, 2) != 0)) begin
            if_addr_a[1] = rand_addr(2'd2);
            if_req_a[1]  = 1'b1;
         end else begin
            if_req_a[1] = 1'b0;
            if (c >= ncyc) break;
         end
      end
      chk1("if_drain", if_req_a[1], 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0] seq;
      int         nseen;
      for (int k = 0; k < 2; k++) begin
         rst_a[k] = 1'b1; if_req_a[k] = 1'b0; if_addr_a[k] = 32'd0;
         d_req_a[k] = 1'b0; d_we_a[k] = 1'b0; d_addr_a[k] = 32'd0;
         d_funct3_a[k] = 3'd0; d_wdata_a[k] = 32'd0;
      end
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst_a[0] = 1'b0;
      rst_a[1] = 1'b0;
      @(negedge clk);
      chk1("reset_busy", busy_a[0], 1'b0);
      chk1("reset_d_rvalid", d_rvalid_a[0], 1'b0);
      chk("reset_d_rdata", d_rdata_a[0], 32'd0);
      chk("reset_if_rdata", if_rdata_a[0], 32'd0);

      // Main function and extension, one wait state.
      xop("sw10",    1, 1'b1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 3);
      xop("lw10",    1, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 3);
      xop("lb13",    1, 1'b1, 1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0, 3);
      xop("lbu13",   1, 1'b1, 1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0, 3);
      xop("lh12",    1, 1'b1, 1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFFDEAD, 1'b0, 3);
      xop("lhu10",   1, 1'b1, 1'b0, 32'h10, 3'b101, 32'h0,        32'h0000BEEF, 1'b0, 3);
      xop("sb11",    1, 1'b1, 1'b1, 32'h11, 3'b000, 32'h12345655, 32'h0,        1'b0, 3);
      xop("lw_sb",   1, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0, 3);
      xop("sh12",    1, 1'b1, 1'b1, 32'h12, 3'b001, 32'h0000CAFE, 32'h0,        1'b0, 3);
      xop("lw_sh",   1, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0,        32'hCAFE55EF, 1'b0, 3);
      // Error cases.
      xop("lw12",    1, 1'b1, 1'b0, 32'h12, 3'b010, 32'h0,        32'h0,        1'b1, 3);
      xop("sw11",    1, 1'b1, 1'b1, 32'h11, 3'b010, 32'h11111111, 32'h0,        1'b1, 3);
      xop("sbu_ill", 1, 1'b1, 1'b1, 32'h10, 3'b100, 32'h22222222, 32'h0,        1'b1, 3);
      xop("lw_kept", 1, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0,        32'hCAFE55EF, 1'b0, 3);
      xop("f3_011",  1, 1'b1, 1'b0, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1, 3);
      xop("fetch02", 1, 1'b0, 1'b0, 32'h02, 3'b010, 32'h0,        32'h0,        1'b1, 3);
      xop("fetch10", 1, 1'b0, 1'b0, 32'h10, 3'b010, 32'h0,        32'hCAFE55EF, 1'b0, 3);

      // Reset during ACCESS aborts the store.
      xop("sw20_0",  1, 1'b1, 1'b1, 32'h20, 3'b010, 32'h0,        32'h0,        1'b0, 3);
      @(posedge clk); #1;
      d_we_a[1] = 1'b1; d_addr_a[1] = 32'h20; d_funct3_a[1] = 3'b010;
      d_wdata_a[1] = 32'hFFFFFFFF; d_req_a[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_a[1] = 1'b1;
      d_req_a[1] = 1'b0;
      @(negedge clk);
      chk1("rst_access_rvalid", d_rvalid_a[1], 1'b0);
      @(posedge clk); #1;
      rst_a[1] = 1'b0;
      @(negedge clk);
      chk1("rst_busy_after", busy_a[1], 1'b0);
      chk1("rst_rvalid_after", d_rvalid_a[1], 1'b0);
      xop("lw20",    1, 1'b1, 1'b0, 32'h20, 3'b010, 32'h0,        32'h0,        1'b0, 3);

      // Preload the random-traffic region.
      for (int w = 0; w < 16; w++) begin
         logic [31:0] rd;
         logic        er;
         int          lat;
         op(1, 1'b1, 1'b1, 32'h100 + 32'(4 * w), 3'b010, $urandom(), rd, er, lat);
      end

      // Arbitration with both requests held from reset.
      @(posedge clk); #1;
      rst_a[1] = 1'b1;
      if_addr_a[1] = 32'h10; if_req_a[1] = 1'b1;
      d_we_a[1] = 1'b0; d_addr_a[1] = 32'h100; d_funct3_a[1] = 3'b010; d_req_a[1] = 1'b1;
      @(posedge clk); #1;
      rst_a[1] = 1'b0;
      seq   = 4'd0;
      nseen = 0;
      for (int c = 0; c < 40 && nseen < 4; c++) begin
         @(negedge clk);
         if (d_rvalid_a[1]) begin
            seq = {seq[2:0], 1'b1};
            nseen++;
         end else if (if_rvalid_a[1]) begin
            seq = {seq[2:0], 1'b0};
            nseen++;
         end
      end
      @(posedge clk); #1;
      if_req_a[1] = 1'b0;
      d_req_a[1]  = 1'b0;
      chk("arb_count", 32'(nseen), 32'd4);
      chk("arb_order", 32'(seq), 32'b1010);

      // Zero wait states and address aliasing.
      xop("z_sw1010", 0, 1'b1, 1'b1, 32'h00001010, 3'b010, 32'hA5A51234, 32'h0,        1'b0, 2);
      xop("z_lw010",  0, 1'b1, 1'b0, 32'h00000010, 3'b010, 32'h0,        32'hA5A51234, 1'b0, 2);
      xop("z_lb3013", 0, 1'b1, 1'b0, 32'h00003013, 3'b000, 32'h0,        32'hFFFFFFA5, 1'b0, 2);
      xop("z_fetch",  0, 1'b0, 1'b0, 32'hFFFFF010, 3'b010, 32'h0,        32'hA5A51234, 1'b0, 2);

      // Randomized concurrent traffic.
      fork
         drive_d(1500);
         drive_if(1500);
      join
      repeat (6) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
